// File: rtl/wave_capture.sv
// Triggered waveform capture: decimates accepted samples into a 1024x14 buffer
// after a level-crossing (or forced) trigger, and exposes the buffer on a registered read port.
module wave_capture #(
  parameter int unsigned AUTO_LIMIT = 4096
) (
  input  logic        clk_dac,
  input  logic        reset,
  input  logic [13:0] sample_in,
  input  logic        sample_valid,
  input  logic        arm,
  input  logic        trig_en,
  input  logic [13:0] trig_level,
  input  logic [3:0]  time_division,
  input  logic [9:0]  rd_addr,
  output logic [13:0] rd_data,
  output logic        busy,
  output logic        done,
  output logic        auto_trig
);

  localparam int unsigned CW = (AUTO_LIMIT < 1) ? 1 : $clog2(AUTO_LIMIT + 1);

  typedef enum logic [1:0] {IDLE, WAIT_TRIG, CAPTURE, DONE} state_t;

  state_t      state;
  logic [13:0] mem [0:1023];
  logic [13:0] prev;
  logic        have_prev;
  logic [CW-1:0] auto_cnt;
  logic [3:0]  dec_cnt;
  logic [3:0]  td_lat;
  logic [9:0]  wr_addr;

  logic        crossed;
  logic        forced;
  logic        fire;
  logic        we;
  logic [9:0]  waddr;

  // The trigger sample is written in the same cycle it is recognised, always at address 0.
  always_comb begin
    crossed = have_prev && (prev < trig_level) && (sample_in >= trig_level);
    forced  = have_prev && (auto_cnt == CW'(AUTO_LIMIT));
    fire    = (state == WAIT_TRIG) && sample_valid && (crossed || forced);
    we      = !reset && (fire || ((state == CAPTURE) && sample_valid && (dec_cnt == '0)));
    waddr   = fire ? '0 : wr_addr;
  end

  always_ff @(posedge clk_dac) begin
    if (reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      auto_trig <= 1'b0;
      prev      <= '0;
      have_prev <= 1'b0;
      auto_cnt  <= '0;
      dec_cnt   <= '0;
      td_lat    <= '0;
      wr_addr   <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (arm) begin
            td_lat    <= time_division;
            auto_trig <= 1'b0;
            wr_addr   <= '0;
            dec_cnt   <= '0;
            auto_cnt  <= '0;
            have_prev <= 1'b0;
            busy      <= 1'b1;
            done      <= 1'b0;
            state     <= trig_en ? WAIT_TRIG : CAPTURE;
          end
        end
        WAIT_TRIG: begin
          if (sample_valid) begin
            prev      <= sample_in;
            have_prev <= 1'b1;
            if (fire) begin
              wr_addr   <= 10'd1;
              dec_cnt   <= '0;
              auto_trig <= forced && !crossed;
              state     <= CAPTURE;
            end else begin
              auto_cnt <= auto_cnt + CW'(1);
            end
          end
        end
        CAPTURE: begin
          if (sample_valid) begin
            dec_cnt <= (dec_cnt == td_lat) ? '0 : dec_cnt + 4'd1;
            if (dec_cnt == '0) begin
              if (wr_addr == '1) begin
                busy  <= 1'b0;
                done  <= 1'b1;
                state <= DONE;
              end else begin
                wr_addr <= wr_addr + 10'd1;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Buffer has no reset so a capture survives a reset.
  always_ff @(posedge clk_dac) begin
    if (we) mem[waddr] <= sample_in;
  end

  always_ff @(posedge clk_dac) begin
    if (reset) rd_data <= '0;
    else       rd_data <= mem[rd_addr];
  end

endmodule

// File: doc/wave_capture.md
WAVE_CAPTURE -- requirements
Module: wave_capture

Interface
REQ-001 The block SHALL have parameter AUTO_LIMIT, default 4096, meaning the count of accepted samples in WAIT_TRIG before a forced trigger.
REQ-002 The block SHALL have port clk_dac, input, 1 bit: the single clock; all logic is rising-edge.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port sample_in, input, 14 bits: unsigned sample from the sine generator.
REQ-005 The block SHALL have port sample_valid, input, 1 bit: sample_in is accepted on any cycle where this is high.
REQ-006 The block SHALL have port arm, input, 1 bit: a single-cycle pulse that starts a capture.
REQ-007 The block SHALL have port trig_en, input, 1 bit: 1 = level trigger, 0 = free-run.
REQ-008 The block SHALL have port trig_level, input, 14 bits: unsigned trigger threshold.
REQ-009 The block SHALL have port time_division, input, 4 bits: decimation, storing 1 of every time_division+1 accepted samples.
REQ-010 The block SHALL have port rd_addr, input, 10 bits: display-side read address.
REQ-011 The block SHALL have port rd_data, output, 14 bits: buffer word at rd_addr.
REQ-012 The block SHALL have port busy, output, 1 bit: high in WAIT_TRIG or CAPTURE.
REQ-013 The block SHALL have port done, output, 1 bit: high in DONE.
REQ-014 The block SHALL have port auto_trig, output, 1 bit: the last capture was force-triggered.

Function
REQ-015 The block SHALL have a 1024 x 14 buffer, written only by the capture FSM and read through a registered read port.
REQ-016 rd_data SHALL equal buffer[rd_addr] one cycle after rd_addr is presented, in every state, including a same-cycle write to that address (old data returned).
REQ-017 The FSM SHALL have states IDLE, WAIT_TRIG, CAPTURE and DONE.
REQ-018 In IDLE or DONE, arm SHALL latch time_division and trig_en, clear auto_trig, and move to WAIT_TRIG (trig_en=1) or CAPTURE (trig_en=0).
REQ-019 In WAIT_TRIG and CAPTURE, arm SHALL be ignored.
REQ-020 In WAIT_TRIG, a trigger SHALL be an accepted sample with prev < trig_level and sample_in >= trig_level, where prev is the previous accepted sample.
REQ-021 The first accepted sample after entering WAIT_TRIG SHALL set prev and SHALL NOT trigger.
REQ-022 If AUTO_LIMIT accepted samples pass in WAIT_TRIG without a trigger, the next accepted sample SHALL trigger and auto_trig SHALL be set.
REQ-023 A triggering sample SHALL be written to address 0, the write address SHALL become 1, the decimation counter SHALL clear, and the FSM SHALL enter CAPTURE.
REQ-024 On entry to CAPTURE from IDLE or DONE (free-run), the write address and decimation counter SHALL be 0, and the first accepted sample SHALL be written to address 0.
REQ-025 In CAPTURE, each accepted sample SHALL advance the decimation counter, which wraps to 0 after reaching the latched time_division.
REQ-026 In CAPTURE, a sample SHALL be written only when the decimation counter equals 0 at acceptance; after each write the address SHALL increment.
REQ-027 In CAPTURE, the write to address 1023 SHALL move the FSM to DONE on the next cycle, with no address wrap.
REQ-028 Changes to time_division or trig_en while busy SHALL have no effect until the next arm.
REQ-029 Cycles with sample_valid low SHALL leave all counters and prev unchanged.

Reset
REQ-030 Reset SHALL force IDLE and zero busy, done, auto_trig, rd_data, prev, the counters and the write address, in any state including mid-capture.
REQ-031 Reset SHALL NOT clear the buffer contents.
REQ-032 Arm asserted together with reset SHALL be ignored.

Verification
REQ-033 Free-run: trig_en=0, time_division=0, arm, then ramp 0..1023 with valid every cycle -> done high 1 cycle after the last write; reading buffer[k] gives k.
REQ-034 Decimation: trig_en=0, time_division=3, ramp 0..4095 -> buffer[k]=4k; done after the sample value 4092 is written.
REQ-035 Trigger: trig_level=8000, sine input -> buffer[0] is the first sample >= 8000 following a sample < 8000; auto_trig=0.
REQ-036 Auto trigger: trig_level=16383, constant input 100 -> capture starts on accepted sample AUTO_LIMIT+1; auto_trig=1; all words are 100.
REQ-037 Reset mid-capture after 500 writes -> next cycle IDLE with busy=0, done=0; buffer[0..499] still readable.
REQ-038 Gaps and ignored arm: sample_valid toggled 1/0 and arm pulsed during CAPTURE -> same buffer as a gap-free run; the capture is not restarted.
